// File: rtl/btn_debounce_multi.sv
`default_nettype none
//==============================================================================
// Module   : btn_debounce_multi
// Purpose  : N-channel button conditioner. Synchronises, debounces on a shared
//            prescaled tick, and emits press/release/auto-repeat pulses.
// Revision : 1.0 - initial release
//==============================================================================
module btn_debounce_multi #(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 100_000,
    parameter int STABLE_CNT   = 10,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_btn,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_rpt,
    output logic            o_tick
);

    localparam int c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CNT - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_tick;

    // With TICK_DIV=1 the divider sits at zero and the tick stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == c_DIV_LAST);
            r_div  <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign o_tick = r_tick;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        logic                   r_lvl;
        logic                   r_lvl_d;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   w_flip;
        logic                   w_rise;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn[k]};
            end
        end

        assign w_s    = r_sync[SYNC_STAGES-1];
        assign w_flip = r_tick && (w_s != r_lvl) && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_lvl_d <= r_lvl;
                if (r_tick) begin
                    if (w_s == r_lvl) begin
                        r_cnt <= '0;
                    end else if (w_flip) begin
                        r_lvl <= w_s;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end

        assign w_rise    = r_lvl & ~r_lvl_d;
        assign o_btn[k]  = r_lvl;
        assign o_rise[k] = w_rise;
        assign o_fall[k] = ~r_lvl & r_lvl_d;

        if (REPEAT_DELAY > 0) begin : g_rpt
            localparam int c_RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int c_RC_W   = $clog2(c_RC_MAX + 1);
            localparam logic [c_RC_W-1:0] c_DELAY_LAST = c_RC_W'(REPEAT_DELAY - 1);
            localparam logic [c_RC_W-1:0] c_RATE_LAST  = c_RC_W'(REPEAT_RATE - 1);

            logic [c_RC_W-1:0] r_rc;
            logic [c_RC_W-1:0] w_target;
            logic              r_rep;
            logic              r_rpt;
            logic              w_fire;

            // A tick that releases the button must not also schedule a repeat.
            assign w_target = r_rep ? c_RATE_LAST : c_DELAY_LAST;
            assign w_fire   = r_tick && r_lvl && !w_flip && (r_rc == w_target);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rc  <= '0;
                    r_rep <= 1'b0;
                    r_rpt <= 1'b0;
                end else begin
                    r_rpt <= 1'b0;
                    if (!r_lvl || w_rise) begin
                        r_rc  <= '0;
                        r_rep <= 1'b0;
                    end else if (w_fire) begin
                        r_rc  <= '0;
                        r_rep <= 1'b1;
                        r_rpt <= 1'b1;
                    end else if (r_tick) begin
                        r_rc <= r_rc + 1'b1;
                    end
                end
            end

            assign o_rpt[k] = r_rpt;
        end else begin : g_no_rpt
            assign o_rpt[k] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_multi.sv
`default_nettype none
//==============================================================================
// Module   : tb_btn_debounce_multi
// Purpose  : Self-checking bench: main instance (TICK_DIV=10) and a TICK_DIV=1
//            corner instance, both compared against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_btn_debounce_multi;

    localparam int c_TD_A = 10, c_SC_A = 4, c_RD_A = 5, c_RR_A = 2;
    localparam int c_TD_B = 1,  c_SC_B = 1, c_RD_B = 0, c_RR_B = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_a = '0, btn_b = '0;
    logic [3:0] a_btn, a_rise, a_fall, a_rpt;
    logic [3:0] b_btn, b_rise, b_fall, b_rpt;
    logic       a_tick, b_tick;
    logic [33:0] w_dut;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_debounce_multi #(.N_CH(4), .SYNC_STAGES(2), .TICK_DIV(c_TD_A), .STABLE_CNT(c_SC_A),
                         .REPEAT_DELAY(c_RD_A), .REPEAT_RATE(c_RR_A)) u_dut_a (
        .clk(clk), .reset(reset), .i_btn(btn_a), .o_btn(a_btn), .o_rise(a_rise),
        .o_fall(a_fall), .o_rpt(a_rpt), .o_tick(a_tick));

    btn_debounce_multi #(.N_CH(4), .SYNC_STAGES(2), .TICK_DIV(c_TD_B), .STABLE_CNT(c_SC_B),
                         .REPEAT_DELAY(c_RD_B), .REPEAT_RATE(c_RR_B)) u_dut_b (
        .clk(clk), .reset(reset), .i_btn(btn_b), .o_btn(b_btn), .o_rise(b_rise),
        .o_fall(b_fall), .o_rpt(b_rpt), .o_tick(b_tick));

    assign w_dut = {a_btn, a_rise, a_fall, a_rpt, a_tick, b_btn, b_rise, b_fall, b_rpt, b_tick};

    // Behavioural model: edge count since reset defines ticks, a two-sample input
    // history stands in for the synchroniser, and run lengths of disagreeing
    // ticks / ticks held decide levels and repeats.
    int         m_n [2];
    logic [3:0] m_h0 [2], m_h1 [2], m_lvl [2], m_lvl_d [2], m_rpt [2];
    logic       m_tick [2];
    int         m_run [2][4];
    int         m_held [2][4];

    task automatic model_step(input int m, input logic [3:0] in, input int td, input int sc,
                              input int rd, input int rr);
        logic [3:0] lvl_nx;
        logic [3:0] rpt_nx;
        if (reset) begin
            m_n[m] = 0; m_h0[m] = '0; m_h1[m] = '0; m_lvl[m] = '0; m_lvl_d[m] = '0;
            m_rpt[m] = '0; m_tick[m] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                m_run[m][c] = 0; m_held[m][c] = 0;
            end
            return;
        end
        lvl_nx = m_lvl[m];
        rpt_nx = '0;
        for (int c = 0; c < 4; c++) begin
            if (m_tick[m]) begin
                if (m_h1[m][c] != m_lvl[m][c]) begin
                    m_run[m][c]++;
                    if (m_run[m][c] == sc) begin
                        lvl_nx[c]   = m_h1[m][c];
                        m_run[m][c] = 0;
                    end
                end else begin
                    m_run[m][c] = 0;
                end
            end
            if (rd > 0) begin
                if (!m_lvl[m][c] || !m_lvl_d[m][c]) begin
                    m_held[m][c] = 0;
                end else if (m_tick[m] && lvl_nx[c]) begin
                    m_held[m][c]++;
                    if (m_held[m][c] == rd || (m_held[m][c] > rd && (m_held[m][c] - rd) % rr == 0))
                        rpt_nx[c] = 1'b1;
                end
            end
        end
        m_lvl_d[m] = m_lvl[m];
        m_lvl[m]   = lvl_nx;
        m_rpt[m]   = rpt_nx;
        m_h1[m]    = m_h0[m];
        m_h0[m]    = in;
        m_n[m]++;
        m_tick[m]  = (m_n[m] >= td) && (m_n[m] % td == 0);
    endtask

    always @(posedge clk) begin
        model_step(0, btn_a, c_TD_A, c_SC_A, c_RD_A, c_RR_A);
        model_step(1, btn_b, c_TD_B, c_SC_B, c_RD_B, c_RR_B);
    end

    function automatic logic [16:0] exp_vec(input int m);
        return {m_lvl[m], m_lvl[m] & ~m_lvl_d[m], ~m_lvl[m] & m_lvl_d[m], m_rpt[m], m_tick[m]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        btn_a = '0;
        btn_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (w_dut !== 34'b0) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", w_dut, 34'b0);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_press();
        int lat = -1, rises = 0, falls = 0;
        btn_a[0] = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL clean_press_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            if (a_btn[0] && lat < 0) lat = i;
            rises += int'(a_rise[0]);
        end
        checks++;
        if (lat < 1 || lat > 43) begin
            errors++;
            $display("FAIL clean_press_latency got %0d expected 1..43", lat);
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL clean_press_rise_count got %0d expected 1", rises);
        end
        btn_a[0] = 1'b0;
        lat = -1;
        rises = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL clean_release_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            if (!a_btn[0] && lat < 0) lat = i;
            falls += int'(a_fall[0]);
            rises += int'(a_rise[0]);
        end
        checks++;
        if (lat < 1 || lat > 43 || falls !== 1 || rises !== 0) begin
            errors++;
            $display("FAIL clean_release got lat=%0d falls=%0d rises=%0d expected lat<=43 falls=1 rises=0", lat, falls, rises);
        end
    endtask

    task automatic test_bounce();
        int changes = 0, rises = 0;
        for (int i = 0; i < 150; i++) begin
            if (i % 7 == 0) btn_a[1] = ~btn_a[1];
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL bounce_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            changes += int'(a_btn[1] | a_rise[1] | a_fall[1]);
        end
        checks++;
        if (changes !== 0) begin
            errors++;
            $display("FAIL bounce_no_change got %0d active cycles expected 0", changes);
        end
        btn_a[1] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL bounce_settle_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            rises += int'(a_rise[1]);
        end
        checks++;
        if (rises !== 1 || a_btn[1] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_settle got rises=%0d btn=%b expected rises=1 btn=1", rises, a_btn[1]);
        end
        btn_a[1] = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_glitch();
        int active = 0;
        btn_a[2] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 25) btn_a[2] = 1'b0;
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL glitch_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            active += int'(a_btn[2] | a_rise[2] | a_fall[2]);
        end
        checks++;
        if (active !== 0) begin
            errors++;
            $display("FAIL glitch_reject got %0d active cycles expected 0", active);
        end
    endtask

    task automatic test_repeat();
        int rise_at = -1, fall_at = -1, last = -1, n_rpt = 0, late_rpt = 0;
        btn_a[3] = 1'b1;
        for (int i = 0; i < 420; i++) begin
            if (i == 300) btn_a[3] = 1'b0;
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL repeat_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            if (a_rise[3]) rise_at = i;
            if (a_fall[3]) fall_at = i;
            if (a_rpt[3]) begin
                if (fall_at >= 0) late_rpt++;
                checks++;
                if (last < 0 && (i - rise_at) !== 50) begin
                    errors++;
                    $display("FAIL repeat_first got %0d cycles after rise expected 50", i - rise_at);
                end else if (last >= 0 && (i - last) !== 20) begin
                    errors++;
                    $display("FAIL repeat_period got %0d cycles expected 20", i - last);
                end
                last = i;
                n_rpt++;
            end
        end
        checks++;
        if (rise_at < 0 || fall_at < 0 || n_rpt < 8 || late_rpt !== 0) begin
            errors++;
            $display("FAIL repeat_summary got rise=%0d fall=%0d rpts=%0d late=%0d expected late=0 rpts>=8",
                     rise_at, fall_at, n_rpt, late_rpt);
        end
    endtask

    task automatic test_simultaneous_reset();
        int seen = 0, lat = -1, falls = 0;
        btn_a = 4'hf;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL simul_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            if (a_rise != 4'h0 && seen == 0) begin
                seen = 1;
                checks++;
                if (a_rise !== 4'hf) begin
                    errors++;
                    $display("FAIL simul_rise got %b expected 1111", a_rise);
                end
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({a_btn, a_rise, a_fall, a_rpt, a_tick} !== 17'b0) begin
            errors++;
            $display("FAIL mid_reset_clear got %h expected 0", {a_btn, a_rise, a_fall, a_rpt, a_tick});
        end
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL post_reset_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            if (a_btn === 4'hf && lat < 0) lat = i;
            falls += int'(a_fall != 4'h0);
        end
        checks++;
        if (seen == 0 || lat < 31 || lat > 43 || falls !== 0) begin
            errors++;
            $display("FAIL post_reset_reassert got seen=%0d lat=%0d falls=%0d expected lat 31..43 falls=0",
                     seen, lat, falls);
        end
        btn_a = '0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_tick1_corner();
        int lat = -1, rises = 0;
        btn_b[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL tick1_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            if (b_btn[0] && lat < 0) lat = i;
            rises += int'(b_rise[0]);
        end
        checks++;
        if (lat < 1 || lat > 4 || rises !== 1 || b_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick1_press got lat=%0d rises=%0d tick=%b expected lat<=4 rises=1 tick=1",
                     lat, rises, b_tick);
        end
        btn_b[0] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (b_btn[0] !== 1'b0) begin
            errors++;
            $display("FAIL tick1_release got %b expected 0", b_btn[0]);
        end
    endtask

    task automatic test_random();
        int idx;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, 3));
                btn_a[idx] = ~btn_a[idx];
            end
            if ($urandom_range(0, 3) == 0) btn_b = btn_b ^ 4'($urandom);
            @(negedge clk);
            checks++;
            if (w_dut !== {exp_vec(0), exp_vec(1)}) begin
                errors++;
                $display("FAIL random_model t=%0t got %h expected %h", $time, w_dut, {exp_vec(0), exp_vec(1)});
            end
            checks++;
            if ((a_rise & a_fall) !== 4'h0 || (b_rise & b_fall) !== 4'h0) begin
                errors++;
                $display("FAIL random_overlap got a=%b b=%b expected 0000", a_rise & a_fall, b_rise & b_fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_repeat();
        test_simultaneous_reset();
        test_tick1_corner();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised N-channel push-button conditioner, the successor to the single-channel `btn_debounce`. Each channel is synchronised to `clk` and sampled on a shared prescaled tick. A channel's debounced level changes only after STABLE_CNT consecutive ticks that disagree with the current level. Per channel, the block emits the debounced level, one-cycle press and release pulses, and an optional auto-repeat pulse for held buttons. It sits between the board button pins and the UART/control FSMs.

## Interface
- N_CH, 4, number of independent button channels (>=1)
- SYNC_STAGES, 2, input synchroniser depth in flops (>=2)
- TICK_DIV, 100_000, `clk` cycles per sample tick (>=1; 1 = sample every cycle)
- STABLE_CNT, 10, consecutive disagreeing ticks required to change level (>=1)
- REPEAT_DELAY, 0, ticks from press to first repeat pulse; 0 disables repeat entirely
- REPEAT_RATE, 1, ticks between subsequent repeat pulses (>=1)

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- i_btn  input  N_CH  raw asynchronous button inputs, bit k = channel k
- o_btn  output  N_CH  debounced level per channel
- o_rise  output  N_CH  one-cycle pulse on each debounced 0->1 transition
- o_fall  output  N_CH  one-cycle pulse on each debounced 1->0 transition
- o_rpt  output  N_CH  one-cycle auto-repeat pulse while held (0 when REPEAT_DELAY=0)
- o_tick  output  1  shared sample tick, exported for debug and bench alignment

## Operation
- **Synchroniser:** per bit, a SYNC_STAGES-deep flop chain; `s[k]` is its last stage.
- **Tick generator:**
  - `div` counter, width `$clog2(TICK_DIV)` (min 1), counts 0..TICK_DIV-1 and wraps.
  - `o_tick` is registered: high for exactly one cycle, in the cycle after `div`==TICK_DIV-1.
  - With TICK_DIV=1, `o_tick` is constantly 1 after the first post-reset cycle.
- **Debounce, per channel:**
  - State: `lvl` and `cnt` (width `$clog2(STABLE_CNT+1)`); all updates occur only in `o_tick` cycles.
  - On tick with `s`==`lvl`: `cnt` <= 0.
  - On tick with `s`!=`lvl` and `cnt`==STABLE_CNT-1: `lvl` <= `s`, `cnt` <= 0.
  - On tick with `s`!=`lvl` otherwise: `cnt` <= `cnt`+1.
  - Between ticks, `cnt` and `lvl` hold.
  - Any single agreeing tick restarts the count (glitch rejection).
- **Edges:**
  - `lvl_d` is `lvl` delayed one cycle.
  - `o_rise` = `lvl & ~lvl_d`; `o_fall` = `~lvl & lvl_d`.
  - Each is exactly one `clk` cycle wide, coincident with the first cycle of the new `o_btn` value.
- **Auto-repeat, per channel (when REPEAT_DELAY>0):**
  - Repeat counter `rc`, width sized for max(REPEAT_DELAY, REPEAT_RATE).
  - Cleared whenever `lvl`==0, and also in the `o_rise` cycle.
  - While `lvl`==1, each tick increments `rc`.
  - When `rc` reaches REPEAT_DELAY-1 (first repeat), or REPEAT_RATE-1 after a repeat has occurred, `o_rpt` pulses for one cycle (registered, the cycle after that tick) and `rc` <= 0.
  - A held button yields the first `o_rpt` REPEAT_DELAY ticks after the press, then one every REPEAT_RATE ticks.
  - Release stops repeats immediately; no `o_rpt` in or after the `o_fall` cycle.
- **Channel independence:** channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.

## Timing
- **Reset:** every register (sync chain, `div`, `o_tick`, `lvl`, `lvl_d`, `cnt`, `rc`, `o_rpt`) = 0. Hence `o_btn`/`o_rise`/`o_fall`/`o_rpt`/`o_tick` = 0 in the cycle after reset is sampled high.
- **Input held high through reset release:** treated as a press. `o_btn` rises after STABLE_CNT ticks, with an `o_rise` pulse.
- **Reset mid-operation:** aborts all counts. No `o_fall` is generated for a level cleared by reset.
- **Latency** from an `i_btn` step to the `o_btn` change:
  - SYNC_STAGES cycles, plus the wait to the next tick, plus (STABLE_CNT-1)·TICK_DIV, plus 1 cycle.
  - Bounded by SYNC_STAGES + STABLE_CNT·TICK_DIV + 1 cycles.
- **Minimum spacing:** debounced edges on one channel are at least STABLE_CNT ticks apart.
- **Pulse overlap:** `o_rise` and `o_fall` are never high together on the same channel.

## Test plan
Parameters for all cases: N_CH=4, TICK_DIV=10, STABLE_CNT=4, SYNC_STAGES=2, REPEAT_DELAY=5, REPEAT_RATE=2.
- **Clean press/release:** reset 2 cycles, `i_btn[0]` 0->1 held 200 cycles, then 0.
  - `o_btn[0]` rises within 2+40+1 cycles of the step.
  - Exactly one `o_rise[0]` pulse; on release, exactly one `o_fall[0]` pulse within 43 cycles.
- **Bounce:** `i_btn[1]` toggles every 7 cycles for 150 cycles, then held 1.
  - No `o_btn[1]` change during bouncing.
  - A single `o_rise[1]` after the input settles.
- **Glitch rejection:** `i_btn[2]` high for 25 cycles (spanning <4 ticks).
  - `o_btn[2]` stays 0; `o_rise`/`o_fall` never assert.
- **Auto-repeat:** `i_btn[3]` held 300 cycles.
  - First `o_rpt[3]` 5 ticks (~50 cycles) after `o_rise[3]`, then every 20 cycles.
  - No `o_rpt` after `o_fall[3]`.
- **Simultaneous and reset:** all four inputs step to 1 together.
  - All `o_rise` bits pulse in the same cycle.
  - Assert reset mid-hold: all outputs go to 0 next cycle with no `o_fall`.
  - After reset release with inputs still high, `o_btn` reasserts after 4 ticks.
- **TICK_DIV=1 corner:** re-run clean press with TICK_DIV=1, STABLE_CNT=1.
  - `o_btn` follows the input with a 2+1+1 cycle latency.
